// File: rtl/stateful_alu_rmw.sv
// Stateful ALU with an internal RAM performing read-modify-write actions.
// Each accepted action walks IDLE -> RD -> EX -> OUT and commits its RAM write on the output handshake.
module stateful_alu_rmw #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ACTION_LEN = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid,
    input  logic [DATA_WIDTH-1:0] operand_1_in,
    input  logic [DATA_WIDTH-1:0] operand_2_in,
    input  logic [DATA_WIDTH-1:0] operand_3_in,
    output logic                  ready_out,
    input  logic [15:0]           page_tbl_out,
    output logic [DATA_WIDTH-1:0] container_out,
    output logic                  container_out_valid,
    input  logic                  ready_in
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EX   = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0001,
        OP_ADDI  = 4'b1001,
        OP_SUB   = 4'b0010,
        OP_SUBI  = 4'b1010,
        OP_SET   = 4'b1110,
        OP_LOAD  = 4'b1011,
        OP_STORE = 4'b1000,
        OP_LOADD = 4'b0111,
        OP_LDADD = 4'b0100,
        OP_LDMAX = 4'b0011,
        OP_CAS   = 4'b1100
    } op_e;

    state_e                  state_q, state_d;
    logic [3:0]              opc_q, opc_d;
    logic [DATA_WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    mem_we;
    logic                    is_mem_op;
    logic [CW-1:0]           offset_ext, base_ext, len_ext, phys_sum;
    logic [DATA_WIDTH-1:0]   ex_result, ex_wdata;
    logic                    ex_we;
    logic                    unused_action;

    assign unused_action = ^{action_in[ACTION_LEN-1:25], action_in[20:0]};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RD;
            ST_RD:   state_d = ST_EX;
            ST_EX:   state_d = ST_OUT;
            ST_OUT:  if (ready_in) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready_out           = (state_q == ST_IDLE);
        container_out_valid = (state_q == ST_OUT);
    end

    assign accept        = action_valid && ready_out;
    assign container_out = result_q;

    // Physical address wraps modulo the RAM depth; overflow compares the raw offset to addr_len.
    always_comb begin
        offset_ext = CW'(operand_2_in[ADDR_WIDTH-1:0]);
        base_ext   = CW'(page_tbl_out[7:0]);
        len_ext    = CW'(page_tbl_out[15:8]);
        phys_sum   = base_ext + offset_ext;
    end

    // Action latch: loads only on acceptance, otherwise holds.
    always_comb begin
        opc_d  = opc_q;
        op1_d  = op1_q;
        op2_d  = op2_q;
        op3_d  = op3_q;
        addr_d = addr_q;
        ovf_d  = ovf_q;
        if (accept) begin
            opc_d  = action_in[24:21];
            op1_d  = operand_1_in;
            op2_d  = operand_2_in;
            op3_d  = operand_3_in;
            addr_d = phys_sum[ADDR_WIDTH-1:0];
            ovf_d  = (offset_ext > len_ext);
        end
    end

    // Compute stage: rd_data_q holds the RAM word read during RD.
    always_comb begin
        ex_result = op3_q;
        ex_wdata  = rd_data_q;
        ex_we     = 1'b0;
        is_mem_op = 1'b0;
        case (opc_q)
            OP_ADD, OP_ADDI: ex_result = op1_q + op2_q;
            OP_SUB, OP_SUBI: ex_result = op1_q - op2_q;
            OP_SET:          ex_result = op2_q;
            OP_LOAD: begin
                is_mem_op = 1'b1;
                ex_result = rd_data_q;
            end
            OP_STORE: begin
                is_mem_op = 1'b1;
                ex_we     = 1'b1;
                ex_wdata  = op1_q;
            end
            OP_LOADD: begin
                is_mem_op = 1'b1;
                ex_we     = 1'b1;
                ex_wdata  = rd_data_q + DATA_WIDTH'(1);
                ex_result = ex_wdata;
            end
            OP_LDADD: begin
                is_mem_op = 1'b1;
                ex_we     = 1'b1;
                ex_wdata  = rd_data_q + op1_q;
                ex_result = ex_wdata;
            end
            OP_LDMAX: begin
                is_mem_op = 1'b1;
                ex_result = rd_data_q;
                if (op1_q > rd_data_q) begin
                    ex_we    = 1'b1;
                    ex_wdata = op1_q;
                end
            end
            OP_CAS: begin
                is_mem_op = 1'b1;
                ex_result = rd_data_q;
                if (rd_data_q == op1_q) begin
                    ex_we    = 1'b1;
                    ex_wdata = op3_q;
                end
            end
            default: ;
        endcase
        if (is_mem_op && ovf_q) begin
            ex_result = op3_q;
            ex_we     = 1'b0;
        end
    end

    // Result and pending write are captured in EX and held through OUT.
    always_comb begin
        result_d  = result_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        if (state_q == ST_EX) begin
            result_d  = ex_result;
            wr_en_d   = ex_we;
            wr_data_d = ex_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opc_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            op3_q     <= '0;
            addr_q    <= '0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            opc_q     <= opc_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            op3_q     <= op3_d;
            addr_q    <= addr_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Write commits only on the output handshake; reset suppresses it.
    assign mem_we = rst_n && (state_q == ST_OUT) && ready_in && wr_en_q;

    // NOTE: the RAM array has no reset so it maps onto block RAM and survives rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wr_data_q;
        end
        if (state_q == ST_RD) begin
            rd_data_q <= mem[addr_q];
        end
    end

endmodule

// File: doc/stateful_alu_rmw.md
STATEFUL_ALU_RMW -- requirements
Module: stateful_alu_rmw

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning operand, container and RAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning RAM address width; depth = 2^ADDR_WIDTH words.
REQ-003 The block SHALL have parameter ACTION_LEN, default 64, meaning action word width; opcode = action_in[24:21].
REQ-004 The block SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port action_in  input  ACTION_LEN  action word.
REQ-007 The block SHALL have port action_valid  input  1  action and operands valid.
REQ-008 The block SHALL have ports operand_1_in, operand_2_in, operand_3_in  input  DATA_WIDTH  operands; operand_2_in[ADDR_WIDTH-1:0] is the RAM offset.
REQ-009 The block SHALL have port ready_out  output  1  block can accept an action.
REQ-010 The block SHALL have port page_tbl_out  input  16  {addr_len[15:8], base_addr[7:0]}, sampled at acceptance.
REQ-011 The block SHALL have port container_out  output  DATA_WIDTH  result, registered.
REQ-012 The block SHALL have port container_out_valid  output  1  result valid.
REQ-013 The block SHALL have port ready_in  input  1  downstream accepts result.

Function
REQ-014 Accept SHALL occur on a cycle with action_valid=1 and ready_out=1; action_valid with ready_out=0 SHALL be ignored.
REQ-015 On accept the block SHALL latch opcode, operands and page entry, and drive ready_out=0 from the next cycle.
REQ-016 States SHALL be: IDLE -> RD (RAM address issued) -> EX (RAM data returned, compute) -> OUT (valid held) -> IDLE.
REQ-017 The RAM SHALL be internal, one write and one read port, 1-cycle registered read latency.
REQ-018 Physical address SHALL be (base_addr + offset) mod 2^ADDR_WIDTH.
REQ-019 An access SHALL be an overflow when offset > addr_len; an overflow SHALL perform no RAM write and SHALL output operand_3.
REQ-020 Opcodes (results modulo 2^DATA_WIDTH, all compares unsigned):
- 0001/1001 add: op1+op2; 0010/1010 sub: op1-op2; 1110 set: op2; no RAM write.
- 1011 load: output mem.
- 1000 store: mem<=op1; output op3.
- 0111 loadd: mem<=mem+1; output mem+1.
- 0100 ldadd: mem<=mem+op1; output mem+op1.
- 0011 ldmax: mem<=max(mem,op1); output old mem.
- 1100 cas: if mem==op1 then mem<=op3; output old mem.
- any other opcode: output op3, no write.
REQ-021 container_out_valid SHALL assert in OUT; with ready_in=1 continuously, accept at cycle T gives container_out_valid=1 for exactly cycle T+3.
REQ-022 While container_out_valid=1 and ready_in=0, container_out and container_out_valid SHALL hold stable.
REQ-023 The RAM write SHALL commit on the OUT cycle with ready_in=1 (handshake), and ready_out SHALL return to 1 on the following cycle.
REQ-024 Back-to-back actions to the same address SHALL observe the previous write (write commits before the next RD).
REQ-025 container_out_valid SHALL be a single-cycle pulse per handshake; no result SHALL be dropped or duplicated.

Reset
REQ-026 On rst_n=0: state=IDLE, ready_out=1, container_out_valid=0, container_out=0, latched action and overflow flag cleared.
REQ-027 Reset mid-operation SHALL discard the pending result and pending RAM write; RAM contents SHALL NOT be cleared.

Verification
REQ-028 addi op1=5, op2=7, ready_in=1 -> container_out=12 at T+3, valid for one cycle, ready_out=1 at T+4.
REQ-029 store op1=0xAA, offset 3, base 4, len 8; then load offset 3 -> load returns 0xAA (address 7).
REQ-030 loadd offset 2 issued three times back-to-back from an initial mem=0 -> outputs 1, 2, 3.
REQ-031 store offset 9, len 8, op3=0x55 -> output 0x55; later load offset 9 with len 15 -> previous content unchanged.
REQ-032 cas mem=10, op1=10, op3=20 -> output 10, mem=20; repeat -> output 20, mem unchanged.
REQ-033 ldmax, ready_in=0 for 4 cycles -> output held stable, no write until ready_in=1; assert rst_n=0 during hold -> no write, valid=0.
